// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush controller for the 5-stage pipeline. It arbitrates
//   three sources of stalls and flushes, from highest to lowest priority:
//   an MMIO wait in MEM, a load-use hazard and a taken branch/jump in EX.
//   From these it drives the PC and pipeline-register load enables and the
//   bubble (flush) controls. A two-state FSM covers multi-cycle MMIO waits
//   and forces a release after a bounded number of cycles. Two wrapping
//   event counters are kept for debug readout.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   Pause                       load-use request from the hazard detector
//   EX_branch_taken             EX redirect request
//   MEM_io_req, io_ready        MEM-stage MMIO access and its completion
//   pc_en .. mem_wb_en          register load enables
//   if_id_flush .. mem_wb_flush load a NOP bubble (valid with matching _en)
//   pc_redirect                 PC loads the branch target
//   io_timeout                  one-cycle pulse after a forced IO_WAIT exit
//   stall_cycles, flush_events  debug counters (wrap modulo 2^CNT_W)
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | normal flow; load-use and branch rules are evaluated here
// S_IO_WAIT | MMIO in MEM outstanding; pipeline frozen until ready/timeout

module pipeline_stall_ctrl #(
  parameter int IO_TIMEOUT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Pause,
  input  logic             EX_branch_taken,
  input  logic             MEM_io_req,
  input  logic             io_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic             io_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IO_TIMEOUT - 1);

  typedef enum logic {S_RUN, S_IO_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lu_mask_q, lu_mask_d;
  logic              io_timeout_q, io_timeout_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              freeze;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    lu_mask_d    = 1'b0;
    io_timeout_d = 1'b0;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;

    case (state_q)
      S_RUN: begin
        if (MEM_io_req && !io_ready) begin
          freeze  = 1'b1;
          state_d = S_IO_WAIT;
          wait_d  = '0;
        end else if (Pause && !lu_mask_q) begin
          // Hold IF/ID/EX, push a bubble into MEM; the load still retires.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          lu_mask_d    = 1'b1;
        end else if (EX_branch_taken) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      S_IO_WAIT: begin
        // A release cycle (ready or timeout) behaves as plain RUN flow.
        if (io_ready) begin
          state_d = S_RUN;
        end else if (wait_q == WAIT_LAST) begin
          state_d      = S_RUN;
          io_timeout_d = 1'b1;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      lu_mask_d    = lu_mask_q;
    end

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      pc_redirect  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      wait_q       <= '0;
      lu_mask_q    <= 1'b0;
      io_timeout_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      lu_mask_q    <= lu_mask_d;
      io_timeout_q <= io_timeout_d;
      if (!pc_en)      stall_q <= stall_q + 1'b1;
      if (pc_redirect) flush_q <= flush_q + 1'b1;
    end
  end

  assign io_timeout   = io_timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Two instances share the inputs:
// u_a uses the default parameters, u_s uses IO_TIMEOUT=4 and CNT_W=4 for the
// timeout and counter-wrap scenarios.
module tb_pipeline_stall_ctrl;

  logic clk, rst, Pause, EX_branch_taken, MEM_io_req, io_ready;

  logic a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
  logic a_if_id_fl, a_id_ex_fl, a_ex_mem_fl, a_mem_wb_fl, a_redir, a_tmo;
  logic [31:0] a_stall, a_flush;

  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_fl, s_id_ex_fl, s_ex_mem_fl, s_mem_wb_fl, s_redir, s_tmo;
  logic [3:0] s_stall, s_flush;

  int errors = 0;
  int checks = 0;

  pipeline_stall_ctrl u_a (
    .clk(clk), .rst(rst), .Pause(Pause), .EX_branch_taken(EX_branch_taken),
    .MEM_io_req(MEM_io_req), .io_ready(io_ready),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en),
    .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
    .if_id_flush(a_if_id_fl), .id_ex_flush(a_id_ex_fl),
    .ex_mem_flush(a_ex_mem_fl), .mem_wb_flush(a_mem_wb_fl),
    .pc_redirect(a_redir), .io_timeout(a_tmo),
    .stall_cycles(a_stall), .flush_events(a_flush)
  );

  pipeline_stall_ctrl #(.IO_TIMEOUT(4), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .Pause(Pause), .EX_branch_taken(EX_branch_taken),
    .MEM_io_req(MEM_io_req), .io_ready(io_ready),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
    .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_flush(s_if_id_fl), .id_ex_flush(s_id_ex_fl),
    .ex_mem_flush(s_ex_mem_fl), .mem_wb_flush(s_mem_wb_fl),
    .pc_redirect(s_redir), .io_timeout(s_tmo),
    .stall_cycles(s_stall), .flush_events(s_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en  = {pc, if_id, id_ex, ex_mem, mem_wb}
  // fl  = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect}
  wire [4:0] a_en = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en};
  wire [4:0] a_fl = {a_if_id_fl, a_id_ex_fl, a_ex_mem_fl, a_mem_wb_fl, a_redir};
  wire [4:0] s_en = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en};
  wire [4:0] s_fl = {s_if_id_fl, s_id_ex_fl, s_ex_mem_fl, s_mem_wb_fl, s_redir};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic p, input logic b,
                       input logic q, input logic y);
    rst = r; Pause = p; EX_branch_taken = b; MEM_io_req = q; io_ready = y;
    #1;
  endtask

  initial begin
    rst = 1'b1; Pause = 1'b1; EX_branch_taken = 1'b0; MEM_io_req = 1'b0; io_ready = 1'b0;
    tick();

    // Reset held 3 cycles with Pause=1: everything low.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      chk("rst_en", a_en, 5'b00000);
      chk("rst_fl", a_fl, 5'b00000);
      tick();
    end
    chk("rst_stall", a_stall, 0);
    chk("rst_tmo", a_tmo, 0);

    drive(0, 0, 0, 0, 0);
    chk("run_en", a_en, 5'b11111);
    chk("run_fl", a_fl, 5'b00000);
    tick();
    chk("run_stall", a_stall, 0);
    chk("run_flushev", a_flush, 0);

    // Single load-use: 1 stall cycle, second cycle masked.
    drive(0, 1, 0, 0, 0);
    chk("lu1_en", a_en, 5'b00011);
    chk("lu1_fl", a_fl, 5'b00100);
    tick();
    chk("lu1_stall", a_stall, 1);
    drive(0, 1, 0, 0, 0);
    chk("lu2_en", a_en, 5'b11111);
    chk("lu2_fl", a_fl, 5'b00000);
    tick();
    chk("lu2_stall", a_stall, 1);
    drive(0, 0, 0, 0, 0);
    tick();

    // Branch coinciding with load-use is dropped, taken next cycle.
    drive(0, 1, 1, 0, 0);
    chk("bl1_en", a_en, 5'b00011);
    chk("bl1_fl", a_fl, 5'b00100);
    tick();
    chk("bl1_stall", a_stall, 2);
    chk("bl1_flushev", a_flush, 0);
    drive(0, 0, 1, 0, 0);
    chk("bl2_en", a_en, 5'b11111);
    chk("bl2_fl", a_fl, 5'b11001);
    tick();
    chk("bl2_flushev", a_flush, 1);
    chk("bl2_stall", a_stall, 2);

    // MMIO wait: ready arrives on the 6th cycle; Pause/branch ignored while frozen.
    for (int i = 0; i < 5; i++) begin
      drive(0, (i == 0), (i == 1), 1, 0);
      chk("io_frz_en", a_en, 5'b00001);
      chk("io_frz_fl", a_fl, 5'b00010);
      tick();
    end
    drive(0, 0, 0, 1, 1);
    chk("io_rel_en", a_en, 5'b11111);
    chk("io_rel_fl", a_fl, 5'b00000);
    tick();
    chk("io_stall", a_stall, 7);
    chk("io_tmo", a_tmo, 0);

    // Stray io_ready in RUN ignored.
    drive(0, 0, 0, 0, 1);
    chk("stray_rdy_en", a_en, 5'b11111);
    tick();

    // MMIO already ready in RUN: load-use still applies.
    drive(0, 1, 0, 1, 1);
    chk("rdy_lu_en", a_en, 5'b00011);
    chk("rdy_lu_fl", a_fl, 5'b00100);
    tick();
    chk("rdy_lu_stall", a_stall, 8);
    drive(0, 0, 0, 0, 0);
    tick();

    drive(1, 0, 0, 0, 0);
    tick();

    // Timeout on the small instance: 4 frozen cycles, then forced release.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      chk("tmo_frz_en", s_en, 5'b00001);
      chk("tmo_frz_fl", s_fl, 5'b00010);
      tick();
      chk("tmo_early", s_tmo, 0);
    end
    drive(0, 0, 0, 1, 0);
    chk("tmo_rel_en", s_en, 5'b11111);
    chk("tmo_rel_fl", s_fl, 5'b00000);
    tick();
    chk("tmo_pulse", s_tmo, 1);
    chk("tmo_stall", s_stall, 4);
    drive(0, 0, 0, 0, 0);
    chk("tmo_after_en", s_en, 5'b11111);
    tick();
    chk("tmo_pulse_end", s_tmo, 0);

    // Counter wrap: 17 stalls via continuous Pause (stall, masked, ...).
    drive(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 33; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    chk("wrap_small", s_stall, 1);
    chk("wrap_big", a_stall, 17);

    // Reset while in IO_WAIT just before the timeout cycle: no pulse.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      tick();
    end
    chk("pre_rst_stall", s_stall, 4);
    drive(1, 0, 0, 1, 0);
    chk("midrst_en", s_en, 5'b00000);
    tick();
    chk("midrst_tmo", s_tmo, 0);
    chk("midrst_stall", s_stall, 0);
    drive(0, 0, 0, 0, 0);
    chk("midrst_run_en", s_en, 5'b11111);
    tick();
    chk("midrst_tmo2", s_tmo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
